// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - funct3 codes, LSU state encoding and request decode helpers
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // funct3[1:0] carries the access size for every legal code
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and load extraction/extension
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'h0;
    case (st_size)
      2'b00: begin
        st_be   = 4'b0001 << st_addr_lo;
        st_data = {4{st_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << st_addr_lo;
        st_data = {2{st_wdata[15:0]}};
      end
      2'b10: begin
        st_be   = 4'b1111;
        st_data = st_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_v  = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
    half_v  = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];
    ld_data = 32'h0;
    case (ld_funct3)
      F3_LB:   ld_data = {{24{byte_v[7]}}, byte_v};
      F3_LH:   ld_data = {{16{half_v[15]}}, half_v};
      F3_LW:   ld_data = ld_rdata;
      F3_LBU:  ld_data = {24'h0, byte_v};
      F3_LHU:  ld_data = {16'h0, half_v};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// rtl/lsu_dmem_ctrl.sv - LSU request/ready handshake to word-wide DMEM with stall and timeout
module lsu_dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        resp_valid_q, resp_err_q;
  logic [31:0] load_data_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;

  logic        req_ok;
  logic [3:0]  st_be;
  logic [31:0] st_data, ld_data;

  assign req_ok = f3_legal(req_we, req_funct3) && !misaligned(req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .st_size    (req_funct3[1:0]),
    .st_addr_lo (req_addr[1:0]),
    .st_wdata   (req_wdata),
    .st_be      (st_be),
    .st_data    (st_data),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_lo_q),
    .ld_rdata   (mem_rdata),
    .ld_data    (ld_data)
  );

  // DONE drops stall so the core advances on the same edge that retires the access
  assign stall = rst_n && (((state_q == LSU_IDLE) && req_valid) || (state_q == LSU_BUSY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= '0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      load_data_q  <= 32'h0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (req_valid && req_ok) begin
            state_q     <= LSU_BUSY;
            cnt_q       <= '0;
            funct3_q    <= req_funct3;
            addr_lo_q   <= req_addr[1:0];
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_we;
            mem_addr_q  <= {req_addr[31:2], 2'b00};
            mem_be_q    <= st_be;
            mem_wdata_q <= req_we ? st_data : 32'h0;
          end else if (req_valid) begin
            state_q      <= LSU_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            load_data_q  <= 32'h0;
          end
        end
        LSU_BUSY: begin
          if (mem_ready || (cnt_q == CNT_LAST)) begin
            state_q      <= LSU_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= !mem_ready;
            load_data_q  <= (mem_ready && !mem_we_q) ? ld_data : 32'h0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LSU_DONE: state_q <= LSU_IDLE;
        default:  state_q <= LSU_IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign load_data  = load_data_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// tb/tb_lsu_dmem_ctrl.sv - vector table plus scoreboard bench for lsu_dmem_ctrl
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, resp_err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_err(resp_err), .load_data(load_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        err;
    logic [31:0] data;
    int          lat;
    int          reqc;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  vec_t tbl[15];
  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int delay,
                              input logic [3:0] be, input logic [31:0] mwdata, input logic err,
                              input logic [31:0] data, input int lat, input int reqc);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.delay = delay;
    v.be = be; v.mwdata = mwdata; v.err = err; v.data = data; v.lat = lat; v.reqc = reqc;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=resp_valid required=no_response");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        check("load_data", load_data, e.data);
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int n = 0;
    int stalls = 0;
    int reqc = 0;
    bit got = 0;
    bit first = 1;
    exp_t e;
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    e.err = v.err; e.data = v.data;
    sb_q.push_back(e);
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (stall) stalls++;
      if (mem_req) begin
        if (first) begin
          check($sformatf("v%0d_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
          check($sformatf("v%0d_be", idx), {28'h0, mem_be}, {28'h0, v.be});
          check($sformatf("v%0d_wdata", idx), mem_wdata, v.mwdata);
          check($sformatf("v%0d_we", idx), {31'h0, mem_we}, {31'h0, v.we});
          first = 0;
        end
        mem_ready = (v.delay >= 0) && (reqc == v.delay);
        mem_rdata = v.rdata;
        reqc++;
      end else begin
        mem_ready = 1'b0;
      end
      if (resp_valid) begin
        got = 1;
        req_valid = 1'b0;
      end
    end
    check($sformatf("v%0d_resp_seen", idx), {31'h0, got}, 32'h1);
    check($sformatf("v%0d_latency", idx), n, v.lat);
    check($sformatf("v%0d_stall_cyc", idx), stalls, v.lat - 1);
    check($sformatf("v%0d_req_cyc", idx), reqc, v.reqc);
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 4'hF, 32'hDEADBEEF, 0, 32'h0, 3, 1);
    tbl[1]  = mk(1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 4'h8, 32'hA5A5A5A5, 0, 32'h0, 3, 1);
    tbl[2]  = mk(1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 2, 4'hC, 32'hBEEFBEEF, 0, 32'h0, 5, 3);
    tbl[3]  = mk(0, 3'b000, 32'h102, 32'h0, 32'h12F45678, 0, 4'h4, 32'h0, 0, 32'hFFFFFFF4, 3, 1);
    tbl[4]  = mk(0, 3'b100, 32'h102, 32'h0, 32'h12F45678, 1, 4'h4, 32'h0, 0, 32'h000000F4, 4, 2);
    tbl[5]  = mk(0, 3'b001, 32'h102, 32'h0, 32'h12F45678, 0, 4'hC, 32'h0, 0, 32'h000012F4, 3, 1);
    tbl[6]  = mk(0, 3'b001, 32'h100, 32'h0, 32'h12348001, 0, 4'h3, 32'h0, 0, 32'hFFFF8001, 3, 1);
    tbl[7]  = mk(0, 3'b101, 32'h100, 32'h0, 32'h12348001, 2, 4'h3, 32'h0, 0, 32'h00008001, 5, 3);
    tbl[8]  = mk(0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 3, 4'hF, 32'h0, 0, 32'hCAFEF00D, 6, 4);
    tbl[9]  = mk(0, 3'b000, 32'h101, 32'h0, 32'h00008000, 0, 4'h2, 32'h0, 0, 32'hFFFFFF80, 3, 1);
    tbl[10] = mk(0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0, 2, 0);
    tbl[11] = mk(1, 3'b001, 32'h101, 32'h5555, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0, 2, 0);
    tbl[12] = mk(0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0, 2, 0);
    tbl[13] = mk(1, 3'b100, 32'h100, 32'h77, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0, 2, 0);
    tbl[14] = mk(0, 3'b010, 32'h200, 32'h0, 32'h0, -1, 4'hF, 32'h0, 1, 32'h0, 18, 16);

    rst_n = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_vec(i, tbl[i]);

    // load_data holds after DONE, and mem_ready outside BUSY has no effect
    run_vec(15, tbl[4]);
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hold_load_data%0d", k), load_data, 32'h000000F4);
      check($sformatf("idle_mem_req%0d", k), {31'h0, mem_req}, 32'h0);
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;

    // reset in the middle of a BUSY load abandons it
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    repeat (3) @(negedge clk);
    check("midbusy_mem_req", {31'h0, mem_req}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_mem_req", {31'h0, mem_req}, 32'h0);
    check("midrst_stall", {31'h0, stall}, 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(16, tbl[0]);

    repeat (2) @(posedge clk);
    check("sb_empty", sb_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
